// File: rtl/ex_alu_mdu.sv
// ex_alu_mdu: MIPS32 execute stage. Single-cycle logic/arith/compare/shift
// ops are combinational. Multiply and divide run iteratively, one bit per
// cycle, into the HI/LO registers and stall upstream while they run.
module ex_alu_mdu #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        alu_op_i,
    input  logic [WIDTH-1:0]  oprand1_i,
    input  logic [WIDTH-1:0]  oprand2_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic              write_enable_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [ADDR_W-1:0] write_addr_o,
    output logic              write_enable_o,
    output logic              stall_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] OP_OR   = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_XOR  = 5'd3;
    localparam logic [4:0] OP_NOR  = 5'd4;
    localparam logic [4:0] OP_ADD  = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SLT  = 5'd7;
    localparam logic [4:0] OP_SLTU = 5'd8;
    localparam logic [4:0] OP_SLL  = 5'd9;
    localparam logic [4:0] OP_SRL  = 5'd10;
    localparam logic [4:0] OP_SRA  = 5'd11;
    localparam logic [4:0] OP_MULT = 5'd12;
    localparam logic [4:0] OP_MULTU= 5'd13;
    localparam logic [4:0] OP_DIV  = 5'd14;
    localparam logic [4:0] OP_DIVU = 5'd15;
    localparam logic [4:0] OP_MFHI = 5'd16;
    localparam logic [4:0] OP_MFLO = 5'd17;
    localparam logic [4:0] OP_MTHI = 5'd18;
    localparam logic [4:0] OP_MTLO = 5'd19;

    logic [1:0]         r_state;
    logic [SH_W-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left each step
    logic [2*WIDTH-1:0] r_prod;    // running product
    logic [WIDTH-1:0]   r_opb;     // multiplier (MUL) or dividend -> quotient (DIV)
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH-1:0]   r_rem;
    logic               r_qneg;    // negate product / quotient at the end
    logic               r_rneg;    // negate remainder at the end
    logic               r_dvz;     // divisor was zero

    logic               w_is_md, w_is_div, w_signed, w_neg1, w_neg2, w_last;
    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic [SH_W-1:0]    w_sh;
    logic [2*WIDTH-1:0] w_prod_nxt, w_prod_fin;
    logic [WIDTH:0]     w_shift, w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt, w_rem_fin, w_quo_fin;

    assign w_is_md  = (alu_op_i >= OP_MULT) && (alu_op_i <= OP_DIVU);
    assign w_is_div = (alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU);
    assign w_signed = (alu_op_i == OP_MULT) || (alu_op_i == OP_DIV);
    assign w_neg1   = w_signed & oprand1_i[WIDTH-1];
    assign w_neg2   = w_signed & oprand2_i[WIDTH-1];
    assign w_mag1   = w_neg1 ? -oprand1_i : oprand1_i;
    assign w_mag2   = w_neg2 ? -oprand2_i : oprand2_i;
    assign w_last   = (r_cnt == SH_W'(WIDTH-1));
    assign w_sh     = oprand2_i[SH_W-1:0];

    // Shift-add step; the final step's sum is also the unsigned product.
    assign w_prod_nxt = r_prod + (r_opb[0] ? r_mcand : '0);
    assign w_prod_fin = r_qneg ? -w_prod_nxt : w_prod_nxt;

    // Restoring division step: bring down the next dividend bit, try subtract.
    assign w_shift   = {r_rem, r_opb[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvsr};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_opb[WIDTH-2:0], w_ge};
    // Divide by zero yields all ones regardless of sign; MIN/-1 falls out naturally.
    assign w_quo_fin = r_dvz ? '1 : (r_qneg ? -w_quo_nxt : w_quo_nxt);
    assign w_rem_fin = r_rneg ? -w_rem_nxt : w_rem_nxt;

    assign hi_o = r_hi;
    assign lo_o = r_lo;

    // FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_opb   <= '0;
            r_dvsr  <= '0;
            r_rem   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dvz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_md) begin
                        r_state <= w_is_div ? S_DIV : S_MUL;
                        r_cnt   <= '0;
                        r_prod  <= '0;
                        r_rem   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, w_mag1};
                        r_opb   <= w_is_div ? w_mag1 : w_mag2;
                        r_dvsr  <= w_mag2;
                        r_qneg  <= w_neg1 ^ w_neg2;
                        r_rneg  <= w_neg1;
                        r_dvz   <= (oprand2_i == '0);
                    end else if (alu_op_i == OP_MTHI) begin
                        r_hi <= oprand1_i;
                    end else if (alu_op_i == OP_MTLO) begin
                        r_lo <= oprand1_i;
                    end
                end
                S_MUL: begin
                    r_prod  <= w_prod_nxt;
                    r_mcand <= r_mcand << 1;
                    r_opb   <= r_opb >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        {r_hi, r_lo} <= w_prod_fin;
                        r_state      <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_opb <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_lo    <= w_quo_fin;
                        r_hi    <= w_rem_fin;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;  // DONE: let the pipeline move on
            endcase
        end
    end

    // Stall while an op is being accepted or iterating; never in reset or DONE.
    always_comb begin
        stall_o = 1'b0;
        if (!rst)
            stall_o = ((r_state == S_IDLE) && w_is_md) ||
                      (r_state == S_MUL) || (r_state == S_DIV);
    end

    // Single-cycle result mux and GPR write request.
    always_comb begin
        result_o       = '0;
        write_addr_o   = '0;
        write_enable_o = 1'b0;
        if (!rst) begin
            if (((alu_op_i >= OP_OR) && (alu_op_i <= OP_SRA)) ||
                (alu_op_i == OP_MFHI) || (alu_op_i == OP_MFLO)) begin
                write_addr_o   = write_addr_i;
                write_enable_o = write_enable_i;
            end
            case (alu_op_i)
                OP_OR:   result_o = oprand1_i | oprand2_i;
                OP_AND:  result_o = oprand1_i & oprand2_i;
                OP_XOR:  result_o = oprand1_i ^ oprand2_i;
                OP_NOR:  result_o = ~(oprand1_i | oprand2_i);
                OP_ADD:  result_o = oprand1_i + oprand2_i;
                OP_SUB:  result_o = oprand1_i - oprand2_i;
                OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, $signed(oprand1_i) < $signed(oprand2_i)};
                OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, oprand1_i < oprand2_i};
                OP_SLL:  result_o = oprand1_i << w_sh;
                OP_SRL:  result_o = oprand1_i >> w_sh;
                OP_SRA:  result_o = $unsigned($signed(oprand1_i) >>> w_sh);
                OP_MFHI: result_o = r_hi;
                OP_MFLO: result_o = r_lo;
                default: result_o = '0;
            endcase
        end
    end

endmodule

// File: doc/ex_alu_mdu.md
# ex_alu_mdu

Parametrised execute stage for the MIPS32 pipeline. It handles single-cycle logic, arithmetic, compare and shift operations, and adds iterative multiply and divide (signed and unsigned) with HI/LO registers and move-to/move-from access. It sits between the ID/EX and EX/MEM pipeline registers. It stalls upstream stages through `stall_o` while a multiply or divide is iterating.

## Interface
- `WIDTH`, default 32: datapath width; must be a power of two ≥ 8.
- `ADDR_W`, default 5: register-file address width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `alu_op_i`  in  5  operation code (encoding below); codes not listed are NOP.
- `oprand1_i`  in  WIDTH  operand 1 (rs value).
- `oprand2_i`  in  WIDTH  operand 2 (rt value or extended immediate).
- `write_addr_i`  in  ADDR_W  destination register.
- `write_enable_i`  in  1  instruction writes a GPR.
- `result_o`  out  WIDTH  GPR write data.
- `write_addr_o`  out  ADDR_W  destination register, passed through for GPR-writing ops.
- `write_enable_o`  out  1  GPR write request.
- `stall_o`  out  1  hold the ID/EX register and all upstream stages.
- `hi_o`, `lo_o`  out  WIDTH  current HI/LO register contents.

## Operation
- Op codes:
  - 0 NOP, 1 OR, 2 AND, 3 XOR, 4 NOR
  - 5 ADD (modulo 2^WIDTH, no overflow trap), 6 SUB, 7 SLT (signed), 8 SLTU
  - 9 SLL, 10 SRL, 11 SRA: shift `oprand1_i` by `oprand2_i[log2(WIDTH)-1:0]`
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU
  - 16 MFHI, 17 MFLO, 18 MTHI, 19 MTLO
- Single-cycle ops (1–11, 16, 17) are combinational.
  - `result_o` carries the result; `write_addr_o = write_addr_i`; `write_enable_o = write_enable_i`.
  - SLT/SLTU return 1 or 0, zero-extended.
- MTHI/MTLO load HI/LO from `oprand1_i` at the clock edge.
  - They drive `write_enable_o = 0`, `result_o = 0`, `write_addr_o = 0`.
- NOP and unlisted codes drive all three GPR outputs to 0.
- Multiply/divide ops (12–15) never write a GPR: `write_enable_o = 0`, `result_o = 0`, `write_addr_o = 0`.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + op 12/13: latch operand magnitudes (signed ops) or raw operands (unsigned ops), latch the result-sign flag, clear the iteration counter, go to MUL.
  - IDLE + op 14/15: same latching, go to DIV.
  - MUL: shift-add, one partial product per cycle, WIDTH cycles. Then write the 2·WIDTH product to {HI,LO}, negating it if the sign flag is set, and go to DONE.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles. Then LO = quotient, HI = remainder, and go to DONE.
    - Signed divide: quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - DONE: `stall_o` = 0 so the pipeline advances past the op still presented. No restart in this state. Next state IDLE.
- `stall_o` = 1 combinationally in IDLE when `alu_op_i` ∈ {12..15}, and throughout MUL/DIV. It is 0 in DONE and IDLE otherwise.
- Divide by zero: completes in normal time, no trap. LO = all ones, HI = dividend after the sign rules.
- Signed overflow, MIN / −1: LO = MIN, HI = 0.
- HI/LO write priority at a given edge: MUL/DIV completion, then MTHI/MTLO. A collision cannot occur because of the stall.

## Timing
- Reset:
  - FSM → IDLE, HI = LO = 0, counter = 0.
  - While `rst` is high, `result_o`, `write_addr_o`, `write_enable_o` and `stall_o` are forced to 0 combinationally.
  - `rst` asserted mid-iteration abandons the op. HI/LO become 0, not a partial result.
- Single-cycle ops: zero added latency; outputs valid in the same cycle as the inputs.
- Multiply/divide, op presented in cycle 0:
  - `stall_o` high in cycles 0..WIDTH (WIDTH+1 cycles).
  - Cycle WIDTH+1 is DONE: `stall_o` = 0, and `hi_o`/`lo_o` already show the new values.
- MFHI/MFLO issued immediately after DONE read the new HI/LO; no forwarding hazard.
- Upstream holds `alu_op_i` and the operands stable while `stall_o` = 1. The block latches operands in cycle 0 and ignores input changes afterwards.
- Back-to-back MULT/DIV: the second op enters at the cycle after DONE (IDLE) and stalls normally.

## Test plan
- OR 0x0F0F0000 | 0x000000FF with we=1, addr=3 → result 0x0F0F00FF, addr 3, we 1, stall 0 in the same cycle.
- ADD 0xFFFFFFFF + 1 → 0x00000000. SLT 0xFFFFFFFF, 1 → 1; SLTU on the same operands → 0. SRA 0x80000000 by 4 → 0xF8000000; SLL 1 by 35 → 0x00000008.
- MULT −3 × 5 → `stall_o` high exactly 33 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. Following MFLO returns 0xFFFFFFF1 with we=1.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 0x1234 / 0 → 33 stall cycles, LO = 0xFFFFFFFF, HI = 0x1234. MTHI 0xAA then MFHI → 0xAA.
- Assert `rst` at cycle 10 of a DIVU → `stall_o`, `write_enable_o` and `result_o` are 0 while reset is high. Afterwards HI = LO = 0, FSM is IDLE, and the next OR completes with zero latency.
